decoder_scan_n: RTL

Parametrised, registered N-to-2^N one-hot decoder with enable, and the successor to the team's 2-to-4 enable decoder.
- Direct mode: the registered output decodes the external select.
- Scan mode: an internal index auto-advances every DWELL cycles and wraps, for digit-select and keypad-column scanning.
- Sits between control logic and multiplexed display/keypad drivers. Output polarity is selectable.

---
 rtl/decoder_scan_n_pkg.sv | 20 ++
 rtl/decoder_scan_n_onehot_dec.sv | 19 +
 rtl/decoder_scan_n.sv | 112 +++++++++++
 3 files changed

// File: rtl/decoder_scan_n_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_scan_pkg;

    // Controller states: OFF and PAUSE drive the inactive pattern.
    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2,
        StPause  = 2'd3
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell counter width; DWELL=1 still gets a 1-bit (constant-zero) counter.
    function automatic int unsigned cnt_width(input int unsigned dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_scan_n_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with optional one-cold output.
module onehot_dec #(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y
);

    // Set the selected bit, then flip the whole word for one-cold outputs.
    always_comb begin
        y      = '0;
        y[sel] = 1'b1;
        if (ACTIVE_LOW) begin
            y = ~y;
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with direct-select and auto-scan modes.
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned N     = 2 ** SEL_W;
    localparam int unsigned CNT_W = cnt_width(DWELL);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;
    localparam logic [N-1:0]     Y_OFF    = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [N-1:0]     y_q, y_d;
    logic [N-1:0]     y_dec;

    // Decode the next index so y lines up with idx in the same cycle.
    onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .sel (idx_d),
        .y   (y_dec)
    );

    // Next-state, index, dwell counter and wrap pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            StOff, StDirect: begin
                if (!en) begin
                    state_d = StOff;
                end else if (mode == MODE_SCAN) begin
                    state_d = StScan;
                    idx_d   = sel;
                    cnt_d   = '0;
                end else begin
                    state_d = StDirect;
                    idx_d   = sel;
                end
            end
            StScan: begin
                if (!en) begin
                    state_d = StPause;
                end else if (mode == MODE_DIRECT) begin
                    state_d = StDirect;
                    idx_d   = sel;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPause: begin
                // Resume keeps the frozen idx/cnt; no advance on the resume edge.
                if (en && mode == MODE_SCAN) begin
                    state_d = StScan;
                end else if (en) begin
                    state_d = StDirect;
                    idx_d   = sel;
                end
            end
            default: state_d = StOff;
        endcase

        y_d = (state_d == StDirect || state_d == StScan) ? y_dec : Y_OFF;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            y_q     <= Y_OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
